// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
//   DEF_DATA_W / DEF_ADDR_W : default data and register-address widths
//   JAL_REG                 : link register written by jump-and-link
//   md_entry_t              : one buffered multiply/divide result
//   arb_state_t             : starvation-control state
package rf_arb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic [DEF_ADDR_W-1:0] JAL_REG = 5'd31;

  // live=0 marks an entry that must be popped without writing
  // (destination r0, or overwritten by a younger WB write).
  typedef struct packed {
    logic                  live;
    logic [DEF_ADDR_W-1:0] dst;
    logic [DEF_DATA_W-1:0] data;
  } md_entry_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUFFERED = 2'd1,
    STARVED  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of the arbiter's request, handshake and register-file signals.
//   master : pipeline side (drives WB/MD requests and decode sources)
//   slave  : arbiter side (drives md_ready, hazards, stall and RF write port)
interface rf_write_arbiter_if
  import rf_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              wb_valid;
  logic              wb_jal;
  logic [ADDR_W-1:0] wb_dst;
  logic [DATA_W-1:0] wb_data;
  logic              md_valid;
  logic              md_ready;
  logic [ADDR_W-1:0] md_dst;
  logic [DATA_W-1:0] md_data;
  logic [ADDR_W-1:0] id_rs;
  logic [ADDR_W-1:0] id_rt;
  logic              raw_hazard;
  logic              stall_req;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport master (
    output wb_valid, wb_jal, wb_dst, wb_data,
    output md_valid, md_dst, md_data,
    output id_rs, id_rt,
    input  md_ready, raw_hazard, stall_req,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  wb_valid, wb_jal, wb_dst, wb_data,
    input  md_valid, md_dst, md_data,
    input  id_rs, id_rt,
    output md_ready, raw_hazard, stall_req,
    output rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/rf_arb_fifo.sv
// In-order buffer for multiply/divide results awaiting the write port.
//   clk, rst_n          : clock, synchronous active-low reset
//   push, push_entry    : append an entry at the tail
//   pop                 : drop the head entry
//   kill_en, kill_addr  : clear the live bit of every entry whose dst matches
//   head, count         : head entry and occupancy
//   live_view, dst_view : per-slot live bits and destinations for hazard compare
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                push,
  input  md_entry_t                           push_entry,
  input  logic                                pop,
  input  logic                                kill_en,
  input  logic [DEF_ADDR_W-1:0]               kill_addr,
  output md_entry_t                           head,
  output logic [$clog2(DEPTH):0]              count,
  output logic [DEPTH-1:0]                    live_view,
  output logic [DEPTH-1:0][DEF_ADDR_W-1:0]    dst_view
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  md_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Popped slots have their live bit cleared so that live_view only ever
  // reports occupied slots. Order below: kill, then pop clear, then push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && (mem[i].dst == kill_addr)) mem[i].live <= 1'b0;
      end
      if (pop) begin
        mem[rd_ptr].live <= 1'b0;
        rd_ptr           <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    live_view = '0;
    dst_view  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      live_view[i] = mem[i].live;
      dst_view[i]  = mem[i].dst;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the register file's single write port between the WB stage
// (always first) and buffered multiply/divide results, with WAW kill,
// RAW hazard detection for decode and a starvation stall request.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of rf_write_arbiter_if (requests, hazards, RF port)
//
// state    | meaning
// IDLE     | MD buffer empty
// BUFFERED | buffer holds entries, head age counting
// STARVED  | live head waited too long; stall_req asserted until it pops
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  rf_write_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int AGE_W = $clog2(STARVE_LIMIT) + 1;

  arb_state_t                   state, state_next;
  logic [AGE_W-1:0]             age, age_next;
  logic [CNT_W-1:0]             count, count_next;
  md_entry_t                    head, push_entry;
  logic [DEPTH-1:0]             live_view;
  logic [DEPTH-1:0][ADDR_W-1:0] dst_view;

  logic [ADDR_W-1:0] wb_dst_eff;
  logic              wb_req, md_ready, md_acc, buf_nonempty;
  logic              sel_head, bypass, pop, push;
  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;

  assign wb_dst_eff   = bus.wb_jal ? JAL_REG : bus.wb_dst;
  assign wb_req       = bus.wb_valid && (wb_dst_eff != '0);
  assign md_ready     = rst_n && (count < CNT_W'(DEPTH));
  assign md_acc       = bus.md_valid && md_ready;
  assign buf_nonempty = (count != '0);
  assign sel_head     = !wb_req && buf_nonempty && head.live;
  assign bypass       = !wb_req && !buf_nonempty && md_acc;
  // A dead head leaves even while WB owns the port.
  assign pop          = buf_nonempty && (!head.live || !wb_req);
  assign push         = md_acc && !bypass;

  // An entry born under a same-cycle WB write to the same register is
  // already stale, as is anything targeting r0.
  always_comb begin
    push_entry      = '0;
    push_entry.live = (bus.md_dst != '0) && !(wb_req && (bus.md_dst == wb_dst_eff));
    push_entry.dst  = bus.md_dst;
    push_entry.data = bus.md_data;
  end

  rf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill_en    (wb_req),
    .kill_addr  (wb_dst_eff),
    .head       (head),
    .count      (count),
    .live_view  (live_view),
    .dst_view   (dst_view)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else if (wb_req) begin
      rf_we_q    <= 1'b1;
      rf_waddr_q <= wb_dst_eff;
      rf_wdata_q <= bus.wb_data;
    end else if (sel_head) begin
      rf_we_q    <= 1'b1;
      rf_waddr_q <= head.dst;
      rf_wdata_q <= head.data;
    end else if (bypass && (bus.md_dst != '0)) begin
      rf_we_q    <= 1'b1;
      rf_waddr_q <= bus.md_dst;
      rf_wdata_q <= bus.md_data;
    end else begin
      rf_we_q    <= 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      age   <= '0;
    end else begin
      state <= state_next;
      age   <= age_next;
    end
  end

  // Next state. In BUFFERED a non-popping cycle always means a live head
  // is waiting, because dead heads pop unconditionally.
  always_comb begin
    count_next = count + CNT_W'(push) - CNT_W'(pop);
    state_next = state;
    age_next   = age;
    unique case (state)
      IDLE: begin
        if (push) state_next = BUFFERED;
      end
      BUFFERED: begin
        if (count_next == '0) begin
          state_next = IDLE;
          age_next   = '0;
        end else if (pop) begin
          age_next   = '0;
        end else if (age == AGE_W'(STARVE_LIMIT - 1)) begin
          state_next = STARVED;
        end else begin
          age_next   = age + AGE_W'(1);
        end
      end
      STARVED: begin
        if (pop) begin
          state_next = (count_next != '0) ? BUFFERED : IDLE;
          age_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        age_next   = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    logic rs_hit, rt_hit;
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_view[i] && (dst_view[i] == bus.id_rs)) rs_hit = 1'b1;
      if (live_view[i] && (dst_view[i] == bus.id_rt)) rt_hit = 1'b1;
    end
    if (rf_we_q && (rf_waddr_q == bus.id_rs)) rs_hit = 1'b1;
    if (rf_we_q && (rf_waddr_q == bus.id_rt)) rt_hit = 1'b1;
    bus.raw_hazard = ((bus.id_rs != '0) && rs_hit) || ((bus.id_rt != '0) && rt_hit);
    bus.stall_req  = (state == STARVED);
    bus.md_ready   = md_ready;
    bus.rf_we      = rf_we_q;
    bus.rf_waddr   = rf_waddr_q;
    bus.rf_wdata   = rf_wdata_q;
  end

endmodule
